// File: rtl/pkt_bufid_free_list_manager_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pkt_bufid_free_list_manager_if : allocate/release/status bundle for the
// bufid free-list manager.   Rev 1.0
// ---------------------------------------------------------------------------
interface pkt_bufid_free_list_manager_if #(
  parameter int BUFID_W = 8
);
  logic               i_bufid_rd;
  logic               o_bufid_valid;
  logic [BUFID_W-1:0] ov_bufid;
  logic               i_bufid_wr;
  logic [BUFID_W-1:0] iv_bufid;
  logic [8:0]         ov_free_pkt_bufid_num;
  logic               o_init_done;
  logic               o_underflow_err;
  logic               o_dup_release_err;

  modport master (
    output i_bufid_rd, i_bufid_wr, iv_bufid,
    input  o_bufid_valid, ov_bufid, ov_free_pkt_bufid_num,
           o_init_done, o_underflow_err, o_dup_release_err
  );

  modport slave (
    input  i_bufid_rd, i_bufid_wr, iv_bufid,
    output o_bufid_valid, ov_bufid, ov_free_pkt_bufid_num,
           o_init_done, o_underflow_err, o_dup_release_err
  );
endinterface
`default_nettype wire

// File: rtl/pkt_bufid_free_list_manager.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pkt_bufid_free_list_manager : circular free list of packet buffer IDs with
// a presence bitmap guarding against duplicate releases.   Rev 1.0
// ---------------------------------------------------------------------------
module pkt_bufid_free_list_manager #(
  parameter int BUFID_NUM = 256,
  parameter int BUFID_W   = 8
) (
  input  wire logic                    i_clk,
  input  wire logic                    i_rst,
  pkt_bufid_free_list_manager_if.slave bus
);

  localparam logic [0:0]         ST_INIT = 1'b0;
  localparam logic [0:0]         ST_RUN  = 1'b1;
  localparam logic [BUFID_W-1:0] LAST_ID = BUFID_W'(BUFID_NUM - 1);

  logic [0:0]           state_q, state_d;
  logic [BUFID_W-1:0]   rptr_q, rptr_d;
  logic [BUFID_W-1:0]   wptr_q, wptr_d;
  logic [8:0]           count_q, count_d;
  logic [BUFID_NUM-1:0] bitmap_q, bitmap_d;
  logic                 init_done_q, init_done_d;
  logic                 valid_q, valid_d;
  logic                 under_q, under_d;
  logic                 dup_q, dup_d;

  logic [BUFID_W-1:0]   mem_q [BUFID_NUM];
  logic                 mem_we;
  logic [BUFID_W-1:0]   mem_wdata;

  logic                 run;
  logic                 pop;
  logic                 id_in_range;
  logic                 rel_ok;
  logic                 rel_bad;
  logic [BUFID_W-1:0]   head_id;

  function automatic logic [BUFID_W-1:0] next_ptr(input logic [BUFID_W-1:0] p);
    return (p == LAST_ID) ? '0 : p + 1'b1;
  endfunction

  assign run         = (state_q == ST_RUN);
  assign head_id     = mem_q[rptr_q];
  assign pop         = run && bus.i_bufid_rd && valid_q;
  assign id_in_range = (32'(bus.iv_bufid) < 32'(BUFID_NUM));
  // Presence is judged on the pre-pop bitmap, so releasing the id being popped counts as a duplicate.
  assign rel_ok      = run && bus.i_bufid_wr && id_in_range && !bitmap_q[bus.iv_bufid];
  assign rel_bad     = run && bus.i_bufid_wr && !(id_in_range && !bitmap_q[bus.iv_bufid]);

  always_comb begin
    state_d     = state_q;
    rptr_d      = rptr_q;
    wptr_d      = wptr_q;
    count_d     = count_q;
    bitmap_d    = bitmap_q;
    init_done_d = init_done_q;
    under_d     = 1'b0;
    dup_d       = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = wptr_q;

    case (state_q)
      ST_INIT: begin
        // Seed the list with ids in ascending order; the write pointer doubles as the id.
        mem_we           = 1'b1;
        mem_wdata        = wptr_q;
        wptr_d           = next_ptr(wptr_q);
        count_d          = count_q + 9'd1;
        bitmap_d[wptr_q] = 1'b1;
        if (wptr_q == LAST_ID) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        under_d = bus.i_bufid_rd && !valid_q;
        dup_d   = rel_bad;
        if (pop) begin
          rptr_d            = next_ptr(rptr_q);
          bitmap_d[head_id] = 1'b0;
        end
        if (rel_ok) begin
          mem_we                 = 1'b1;
          mem_wdata              = bus.iv_bufid;
          wptr_d                 = next_ptr(wptr_q);
          bitmap_d[bus.iv_bufid] = 1'b1;
        end
        count_d = count_q + 9'(rel_ok) - 9'(pop);
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    valid_d = (count_d != 9'd0) && init_done_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_INIT;
      rptr_q      <= '0;
      wptr_q      <= '0;
      count_q     <= '0;
      bitmap_q    <= '0;
      init_done_q <= 1'b0;
      valid_q     <= 1'b0;
      under_q     <= 1'b0;
      dup_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rptr_q      <= rptr_d;
      wptr_q      <= wptr_d;
      count_q     <= count_d;
      bitmap_q    <= bitmap_d;
      init_done_q <= init_done_d;
      valid_q     <= valid_d;
      under_q     <= under_d;
      dup_q       <= dup_d;
    end
  end

  // Array contents are don't-care until INIT rewrites them, so no reset here.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem_q[wptr_q] <= mem_wdata;
    end
  end

  assign bus.o_bufid_valid         = valid_q;
  assign bus.ov_bufid              = valid_q ? head_id : '0;
  assign bus.ov_free_pkt_bufid_num = count_q;
  assign bus.o_init_done           = init_done_q;
  assign bus.o_underflow_err       = under_q;
  assign bus.o_dup_release_err     = dup_q;

endmodule
`default_nettype wire

// File: doc/pkt_bufid_free_list_manager.md
Name: pkt_bufid_free_list_manager

Overview:
- Owns the pool of packet buffer IDs (bufids) for the packet centralized buffer.
- Hands out free bufids to the packet-write path and takes back released bufids from the packet-read/transmit path.
- Drives the live free-bufid count consumed by the pcb command parse/encapsulate stage, which reports it on management reads of fixed address 0.
- Sits directly upstream of that stage.

Parameters:
- BUFID_NUM, 256, number of bufids in the pool; legal range 2..256.
- BUFID_W, 8, bufid width; must satisfy 2^BUFID_W >= BUFID_NUM.

Ports:
- i_clk  input  1  single clock
- i_rst  input  1  asynchronous, active-high reset
- i_bufid_rd  input  1  allocate request; pops head bufid this cycle
- o_bufid_valid  output  1  head bufid available (free count > 0 and init done)
- ov_bufid  output  BUFID_W  head bufid, show-ahead; meaningful only when o_bufid_valid=1
- i_bufid_wr  input  1  release strobe
- iv_bufid  input  BUFID_W  bufid being released
- ov_free_pkt_bufid_num  output  9  current free-bufid count, registered
- o_init_done  output  1  high once the pool is fully initialized
- o_underflow_err  output  1  one-cycle pulse: allocate while not valid
- o_dup_release_err  output  1  one-cycle pulse: release of an id that is already free, or an id >= BUFID_NUM

Behaviour:
- Reset (asynchronous, i_rst=1):
  - All outputs go to 0.
  - Read pointer, write pointer and count go to 0.
  - Free bitmap is cleared.
  - FSM enters INIT.
- Storage:
  - Circular array of BUFID_NUM entries, BUFID_W bits each.
  - Read and write pointers wrap from BUFID_NUM-1 to 0.
  - A BUFID_NUM-bit free bitmap has bit k = 1 when id k is in the list.
- FSM states: INIT, RUN.
- INIT:
  - One id is written per cycle, ids 0,1,...,BUFID_NUM-1 in order.
  - On each write: wptr++, count++, the id's bitmap bit is set.
  - i_bufid_rd and i_bufid_wr are ignored, with no error pulses.
  - After writing id BUFID_NUM-1, the next cycle enters RUN and sets o_init_done=1.
  - INIT takes exactly BUFID_NUM cycles after reset release.
- RUN, allocate:
  - A pop occurs when i_bufid_rd=1 and o_bufid_valid=1. The consumer samples ov_bufid in that same cycle.
  - On a pop: rptr++, the id's bitmap bit is cleared, count--.
  - The next head appears on ov_bufid one cycle later.
  - i_bufid_rd=1 with o_bufid_valid=0: no state change; o_underflow_err pulses the next cycle.
- RUN, release:
  - i_bufid_wr=1 with a legal id whose bitmap bit is 0: the id is written at wptr, wptr++, the bit is set, count++.
  - Bitmap bit already 1, or iv_bufid >= BUFID_NUM: the release is dropped and o_dup_release_err pulses the next cycle.
- Simultaneous pop and legal release in the same cycle:
  - Both take effect and count is unchanged.
  - If count was 0, o_bufid_valid is 0, so the pop does not happen (underflow pulse) and the release is accepted.
  - Releasing the id being popped in the same cycle is a duplicate: the bitmap is checked before the pop's clear, so it flags an error.
- Full condition:
  - count equals BUFID_NUM only when every id is free.
  - Bitmap checking makes overflow impossible, so there is no separate overflow path.
- Outputs:
  - o_bufid_valid = (count != 0) && o_init_done, registered together with count.
  - Release into an empty list: o_bufid_valid=1 and ov_bufid equals the released id one cycle after the release strobe.
  - ov_free_pkt_bufid_num is zero-extended from the internal count and updates the cycle after each accepted event. Maximum value is 256 (9'h100).
- Reset asserted mid-operation: all state is discarded immediately; after release the block re-runs INIT from id 0.

Test Plan:
1. Release reset, no traffic -> o_init_done rises 256 cycles later; ov_free_pkt_bufid_num=256; o_bufid_valid=1; ov_bufid=0.
2. After init, pulse i_bufid_rd for 3 consecutive cycles -> ids 0,1,2 taken; ov_bufid=3; count=253.
3. Allocate all 256 ids, then one more i_bufid_rd -> o_bufid_valid=0, count=0, one o_underflow_err pulse; then release id 0x5A -> next cycle o_bufid_valid=1, ov_bufid=0x5A, count=1.
4. With count=10, apply i_bufid_rd and a legal release of an allocated id in the same cycle -> count stays 10, no error pulses.
5. Release id 7 while it is still free (never allocated) -> o_dup_release_err pulses once, count unchanged. Then allocate id 7, release it twice -> first accepted, second flagged.
6. Assert i_rst while at count=100 mid-RUN -> outputs go to 0 immediately; after release INIT repeats and count returns to 256.
